// File: rtl/seg_display_mux_pkg.sv
// Shared display constants for the seven-segment path: active-low segment
// patterns in {g,f,e,d,c,b,a} order, blank levels and the default digit count.
// The sequence stage imports the same package, so both sides agree on these values.
package seg_display_mux_pkg;

  localparam int NUM_DIGITS_DEF = 8;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/seg_display_mux_hex_to_seg7.sv
// Combinational nibble to seven-segment decoder (active-low, {g,f,e,d,c,b,a}).
module hex_to_seg7
  import seg_display_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Plain lookup from the hex digit to its segment pattern.
  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Seven-segment display multiplexer. A pending buffer accepts a new hex value
// through a load handshake. That value moves into the active buffer only on the
// frame-boundary tick, so a frame never shows a mix of old and new digits. Each
// pxl_clk tick registers the anode/segment/dp drive for the digit named by seq_sel.
module seg_display_mux
  import seg_display_mux_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int SEL_W      = 3,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pxl_clk,
  input  logic [SEL_W-1:0]        seq_sel,
  input  logic                    load_req,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    load_busy,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int DATA_W = 4 * NUM_DIGITS;

  logic [DATA_W-1:0]     active;
  logic [DATA_W-1:0]     pend;
  logic [31:0]           sel_ext;
  logic                  in_range;
  logic                  boundary;
  logic                  swap;
  logic                  accept;
  logic [3:0]            nibble;
  logic                  dp_bit;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  lz_hit;
  logic                  blank;
  logic [6:0]            seg_raw;

  assign sel_ext  = 32'(seq_sel);
  assign in_range = (sel_ext < 32'(NUM_DIGITS));
  assign boundary = pxl_clk & (sel_ext == 32'(NUM_DIGITS - 1));
  assign swap     = boundary & load_busy;
  // A load is accepted when the pending slot is free, or when the slot is
  // being emptied into active on this same boundary tick.
  assign accept   = load_req & (~load_busy | boundary);

  // Mark each digit whose own nibble and every more-significant nibble are zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run          = run & (active[4*k +: 4] == 4'h0);
      lead_zero[k] = run;
    end
  end

  // Pick the nibble, dp bit and anode for the selected digit. Out-of-range
  // selects match no digit and fall through to the blank case.
  always_comb begin
    nibble = 4'h0;
    dp_bit = 1'b0;
    onehot = '0;
    lz_hit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_ext == 32'(k)) begin
        nibble    = active[4*k +: 4];
        dp_bit    = dp_in[k];
        onehot[k] = 1'b1;
        lz_hit    = (k != 0) && lead_zero[k];
      end
    end
  end

  assign blank = ~in_range | (BLANK_LZ & lz_hit);

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  // Double buffer: load into pend, then hand pend to active at the frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active    <= '0;
      pend      <= '0;
      load_busy <= 1'b0;
    end else begin
      if (swap) begin
        active <= pend;
      end
      if (accept) begin
        pend      <= load_data;
        load_busy <= 1'b1;
      end else if (swap) begin
        load_busy <= 1'b0;
      end
    end
  end

  // One-clock pulse marking the tick that showed the last digit of a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
    end
  end

  // Output drive registers update only on a digit tick and hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (pxl_clk) begin
      if (blank) begin
        an  <= '1;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= ~onehot;
        seg <= seg_raw;
        dp  <= ~dp_bit;
      end
    end
  end

endmodule
